fnd_scan_ctrl: RTL

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

---
 rtl/fnd_pkg.sv | 26 ++
 rtl/fnd_decoder.sv | 25 ++
 rtl/fnd_scan_ctrl.sv | 69 ++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a} with the dp bit off.
package fnd_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] COM_OFF = 4'b1111;

  // Active-low common for one digit.
  function automatic logic [3:0] com_mask(input digit_idx_t sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/fnd_decoder.sv
// Combinational BCD to active-low 7-segment decode; codes 10..15 blank the digit.
module fnd_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0[6:0];
      4'd1:    o_seg = SEG_1[6:0];
      4'd2:    o_seg = SEG_2[6:0];
      4'd3:    o_seg = SEG_3[6:0];
      4'd4:    o_seg = SEG_4[6:0];
      4'd5:    o_seg = SEG_5[6:0];
      4'd6:    o_seg = SEG_6[6:0];
      4'd7:    o_seg = SEG_7[6:0];
      4'd8:    o_seg = SEG_8[6:0];
      4'd9:    o_seg = SEG_9[6:0];
      default: o_seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed driver for four 7-segment digits with an anti-ghost blanking window.
// Commons and font are registered together, one cycle behind cnt/o_sel.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 100
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [3:0] i_digit,
  input  logic [3:0] i_dp,
  output logic [1:0] o_sel,
  output logic [3:0] o_fndCom,
  output logic [7:0] o_fndFont
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK   = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_sel;
  logic [3:0]       r_com;
  logic [7:0]       r_font;

  logic       w_tick;
  logic       w_blank;
  logic       w_dp;
  logic [6:0] w_seg;

  fnd_decoder u_dec (
    .i_bcd (i_digit),
    .o_seg (w_seg)
  );

  assign w_tick  = (r_cnt == CNT_MAX);
  // The blanking window starts each slot right after o_sel moves, so the
  // external mux has settled before any common is driven.
  assign w_blank = !i_en || (r_cnt < BLANK);
  assign w_dp    = i_dp[r_sel];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_sel  <= '0;
      r_com  <= COM_OFF;
      r_font <= SEG_BLANK;
    end else begin
      // Disabling freezes the scan position, which also swallows a coincident tick.
      if (i_en) begin
        r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
        if (w_tick) begin
          r_sel <= r_sel + 2'd1;
        end
      end
      r_com  <= w_blank ? COM_OFF : com_mask(r_sel);
      r_font <= {~w_dp, w_seg};
    end
  end

  assign o_sel     = r_sel;
  assign o_fndCom  = r_com;
  assign o_fndFont = r_font;

endmodule
